state_seek_ctrl: RTL and testbench
==================================

# state_seek_ctrl

Sequencer for the 2-bit, four-state machine: it accepts a target state over a valid/ready handshake and drives the machine's direction (`sw`) and step-enable inputs one step at a time. It takes the shortest modular path, waits a programmable dwell between steps, and checks each step against the observed state. It sits between the switch/command logic and the four-state register and reports completion or a stuck-machine error.

## Interface
- `DWELL_CYCLES`, default 4: idle cycles between consecutive steps; legal range 1–255.
- `TIMEOUT_CYCLES`, default 8: cycles allowed in WAIT for the expected state; legal range 1–255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  target request valid.
- `req_ready`  out  1  high only in IDLE.
- `req_target`  in  2  requested state (0–3).
- `q_in`  in  2  observed state of the four-state machine.
- `step_en`  out  1  one-cycle enable; the controlled machine moves one step at the next edge.
- `sw`  out  1  direction to the machine: 1 = up (Q+1 mod 4), 0 = down (Q−1 mod 4).
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the target is reached.
- `err`  out  1  sticky error flag.

## Operation
- States: IDLE, STEP, WAIT, DWELL, DONE, ERR.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch the target, clear `err`, and compute delta=(req_target−q_in) mod 4.
  - delta 0 → DONE with no steps.
  - delta 1 → `sw`=1, 1 step.
  - delta 2 → `sw`=1 (tie resolves up), 2 steps.
  - delta 3 → `sw`=0, 1 step.
  - Go to STEP.
- STEP:
  - `step_en`=1 for exactly this cycle.
  - Latch prev=q_in and expected=q_in±1 mod 4.
  - Go to WAIT; the timeout counter loads TIMEOUT_CYCLES.
- WAIT:
  - q_in==expected → decrement steps_left; go to DONE if it is 0, else DWELL (counter loads DWELL_CYCLES).
  - q_in==prev → keep waiting and decrement the timeout; at 0 → ERR.
  - Any other value → ERR immediately.
- DWELL: q_in is ignored; count down; at 0 → STEP.
- DONE: `done`=1 for one cycle → IDLE.
- ERR: set `err` (it remains set until the next accepted request) → IDLE next cycle.
- `sw` is registered. It changes only on request acceptance and is held through completion; its reset value is 0.
- `req_valid` while busy: ignored; `req_ready`=0; no queuing.
- `req_target` is sampled only at acceptance. Changes afterwards have no effect.
- Reset asserted mid-operation: the state goes to IDLE immediately and all outputs return to reset values asynchronously. Any half-issued step is abandoned.
- Reset values: `req_ready`=1, `step_en`=0, `sw`=0, `busy`=0, `done`=0, `err`=0.

## Timing
All counts below are in cycles after the acceptance edge:
- delta 0: DONE in cycle 1 (`done` high in cycle 1).
- 1 step: STEP in cycle 1, WAIT in cycle 2 (match), DONE in cycle 3.
- 2 steps: STEP in cycle 1, WAIT in cycle 2, DWELL in cycles 3..2+D, STEP in cycle 3+D, WAIT in cycle 4+D, DONE in cycle 5+D (D=DWELL_CYCLES).
- The controlled machine is expected to update q_in at the edge ending the STEP cycle. With zero extra delay, WAIT lasts one cycle.
- Timeout: with q_in stuck, ERR is entered after TIMEOUT_CYCLES WAIT cycles and `err` rises in the following cycle.
- Earliest next acceptance: the cycle after DONE or ERR, i.e. a new request can be accepted in cycle 4 after a single-step request.
- Outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs except through `req_ready` (state-only).

## Structure
- Package `state_seek_pkg`:
  - state enum;
  - `DIR_UP`=1, `DIR_DOWN`=0;
  - function `mod4_delta(target, cur)`;
  - counter width constant (8).
- Sub-module `cycle_timer`: an 8-bit loadable down-counter with `load`, `load_val`, `dec` and a `zero` flag. One instance is shared by DWELL and WAIT, which are never concurrent.
- The top-level FSM is kept in one file. Bench model: a behavioural four-state register driven by `step_en`/`sw`.

## Test plan
- After reset: `req_ready`=1 and all other outputs 0. Request target 0 with q_in=0 → `done` in cycle 1, `step_en` never high.
- q_in=1, target=2 → `sw`=1, a single `step_en` pulse in cycle 1, `done` in cycle 3.
- q_in=0, target=3 → `sw`=0 (down), one step, final q_in=3, `done` in cycle 3.
- q_in=1, target=3, DWELL_CYCLES=4 → `sw`=1, `step_en` pulses in cycles 1 and 7, `done` in cycle 9.
- Model frozen (q_in never changes), TIMEOUT_CYCLES=8 → ERR entered after 8 WAIT cycles and `err` latched high. The next accepted request clears `err`.
- Reset asserted during DWELL of a 2-step move → outputs return to reset values immediately and no further `step_en`. Plus: `req_valid` held high while busy → `req_ready`=0 and the request is not accepted.

Source files
------------

// File: rtl/state_seek_pkg.sv
// state_seek_pkg: shared types and helpers for the state_seek_ctrl sequencer.
//   seek_state_e : controller FSM states
//   DIR_UP/DOWN  : encoding of the sw direction output
//   CNT_W        : width of the shared dwell/timeout counter
//   mod4_delta() : forward distance from cur to target on the 4-state ring
package state_seek_pkg;

    localparam int   CNT_W    = 8;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_WAIT,
        ST_DWELL,
        ST_DONE,
        ST_ERR
    } seek_state_e;

    // A 2-bit subtraction wraps naturally, which is exactly mod 4.
    function automatic logic [1:0] mod4_delta(input logic [1:0] target,
                                              input logic [1:0] cur);
        return target - cur;
    endfunction

endpackage

// File: rtl/state_seek_ctrl_cycle_timer.sv
// cycle_timer: loadable down-counter shared by the dwell and timeout phases.
//   clk, reset (async, active-low)
//   load, load_val : synchronous load (wins over dec)
//   dec            : count down by one, saturating at zero
//   zero           : counter currently reads zero
module cycle_timer
    import state_seek_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/state_seek_ctrl.sv
// state_seek_ctrl: steps a four-state machine to a requested state along the
// shortest modular path, one verified step at a time.
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_target : target request handshake (ready only in IDLE)
//   q_in     : observed state of the controlled machine
//   step_en  : one-cycle step strobe to the machine
//   sw       : step direction, 1 = up, 0 = down (held from acceptance to completion)
//   busy     : controller not idle
//   done     : one-cycle completion pulse
//   err      : sticky stuck/wrong-state flag, cleared by the next accepted request
module state_seek_ctrl
    import state_seek_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_target,
    input  logic [1:0] q_in,
    output logic       step_en,
    output logic       sw,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // The timer is checked for zero on the last cycle of a phase, so loading
    // N-1 gives exactly N cycles of DWELL or WAIT.
    localparam logic [CNT_W-1:0] DWELL_LOAD   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    seek_state_e state_q;
    logic [1:0]  steps_left_q;
    logic [1:0]  prev_q;
    logic [1:0]  exp_q;
    logic        sw_q, step_en_q, done_q, busy_q, ready_q, err_q;

    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_load_val;

    cycle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Timer control mirrors the transitions below: load on STEP (timeout),
    // load on a non-final match (dwell), count while waiting or dwelling.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        unique case (state_q)
            ST_STEP: begin
                tmr_load     = 1'b1;
                tmr_load_val = TIMEOUT_LOAD;
            end
            ST_WAIT: begin
                if (q_in == exp_q) begin
                    if (steps_left_q != 2'd1) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = DWELL_LOAD;
                    end
                end else if (q_in == prev_q) begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DWELL: tmr_dec = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            steps_left_q <= '0;
            prev_q       <= '0;
            exp_q        <= '0;
            sw_q         <= DIR_DOWN;
            step_en_q    <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            step_en_q <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // The delta and step count fully capture the target, so
                    // later changes on req_target cannot matter.
                    if (req_valid) begin
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        unique case (mod4_delta(req_target, q_in))
                            2'd0: begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                            2'd1: begin
                                sw_q         <= DIR_UP;
                                steps_left_q <= 2'd1;
                                state_q      <= ST_STEP;
                                step_en_q    <= 1'b1;
                            end
                            2'd2: begin
                                sw_q         <= DIR_UP;
                                steps_left_q <= 2'd2;
                                state_q      <= ST_STEP;
                                step_en_q    <= 1'b1;
                            end
                            default: begin
                                sw_q         <= DIR_DOWN;
                                steps_left_q <= 2'd1;
                                state_q      <= ST_STEP;
                                step_en_q    <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_STEP: begin
                    prev_q  <= q_in;
                    exp_q   <= (sw_q == DIR_UP) ? q_in + 2'd1 : q_in - 2'd1;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (q_in == exp_q) begin
                        steps_left_q <= steps_left_q - 2'd1;
                        if (steps_left_q == 2'd1) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DWELL;
                        end
                    end else if (q_in == prev_q) begin
                        if (tmr_zero) begin
                            state_q <= ST_ERR;
                        end
                    end else begin
                        // Machine moved somewhere other than one step: not recoverable.
                        state_q <= ST_ERR;
                    end
                end
                ST_DWELL: begin
                    if (tmr_zero) begin
                        state_q   <= ST_STEP;
                        step_en_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                ST_ERR: begin
                    err_q   <= 1'b1;
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign step_en   = step_en_q;
    assign sw        = sw_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_state_seek_ctrl.sv
// tb_state_seek_ctrl: self-checking bench for state_seek_ctrl. A behavioural
// four-state register reacts to step_en/sw; expected per-cycle behaviour of
// each move is derived from the target distance and the dwell/timeout values.
module tb_state_seek_ctrl;

    localparam int D = 4;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_target;
    logic [1:0] q_model;
    logic       step_en, sw, busy, done, err;

    // Model controls, driven from the initial block.
    logic       q_load;
    logic [1:0] q_load_val;
    logic       frozen;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    state_seek_ctrl #(.DWELL_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .q_in       (q_model),
        .step_en    (step_en),
        .sw         (sw),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Behavioural controlled machine: one modular step per step_en.
    always @(posedge clk) begin
        if (q_load) begin
            q_model <= q_load_val;
        end else if (step_en && !frozen) begin
            q_model <= sw ? 2'((q_model + 1) % 4) : 2'((q_model + 3) % 4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(input int v);
        q_load     = 1'b1;
        q_load_val = 2'(v);
        tick();
        q_load     = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({req_ready, step_en, sw, busy, done, err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 100000",
                     {req_ready, step_en, sw, busy, done, err});
        end
    endtask

    // One complete move from q0 to tgt. With hold set, req_valid stays high
    // (with a different target) while busy, which must have no effect.
    task automatic run_move(input int q0, input int tgt, input bit hold);
        int delta, n, done_c;
        bit dir, exp_step;
        logic [4:0] exp_v, got_v;
        set_q(q0);
        delta  = (tgt - q0 + 4) % 4;
        n      = (delta == 0) ? 0 : (delta == 2) ? 2 : 1;
        dir    = (delta != 3);
        done_c = (n == 0) ? 1 : (n == 1) ? 3 : 5 + D;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready q0=%0d tgt=%0d: got %b want 1", q0, tgt, req_ready);
        end
        req_valid  = 1'b1;
        req_target = 2'(tgt);
        tick();
        if (!hold) req_valid = 1'b0;
        else req_target = 2'((tgt + 1) % 4);
        for (int c = 1; c <= done_c + 1; c++) begin
            exp_step = (n >= 1 && c == 1) || (n == 2 && c == 3 + D);
            exp_v    = {exp_step, c == done_c, c <= done_c, c > done_c, 1'b0};
            got_v    = {step_en, done, busy, req_ready, err};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL move q0=%0d tgt=%0d cycle=%0d {step,done,busy,ready,err}: got %b want %b",
                         q0, tgt, c, got_v, exp_v);
            end
            if (n > 0 && c <= done_c) begin
                checks++;
                if (sw !== dir) begin
                    errors++;
                    $display("FAIL sw q0=%0d tgt=%0d cycle=%0d: got %b want %b", q0, tgt, c, sw, dir);
                end
            end
            if (c == done_c) req_valid = 1'b0;
            tick();
        end
        checks++;
        if (q_model !== 2'(tgt)) begin
            errors++;
            $display("FAIL final_q q0=%0d tgt=%0d: got %0d want %0d", q0, tgt, q_model, tgt);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp_v, got_v;
        set_q(2);
        frozen     = 1'b1;
        req_valid  = 1'b1;
        req_target = 2'd3;
        tick();
        req_valid = 1'b0;
        // STEP in 1, WAIT in 2..1+T, ERR in 2+T, err visible from 3+T.
        for (int c = 1; c <= T + 4; c++) begin
            exp_v = {c == 1, 1'b0, c <= T + 2, c >= T + 3};
            got_v = {step_en, done, busy, err};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL timeout cycle=%0d {step,done,busy,err}: got %b want %b", c, got_v, exp_v);
            end
            tick();
        end
        frozen = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        // run_move checks err==0 from cycle 1 onward, i.e. cleared at acceptance.
        run_move(2, 3, 1'b0);
    endtask

    task automatic test_reset_in_dwell();
        set_q(1);
        req_valid  = 1'b1;
        req_target = 2'd3;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c < 4; c++) tick();
        // Now in cycle 4, inside DWELL (cycles 3..2+D).
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, step_en, sw, busy, done, err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_mid_dwell: got %b want 100000",
                     {req_ready, step_en, sw, busy, done, err});
        end
        tick();
        tick();
        #3;
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if ({step_en, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL after_reset cycle=%0d {step,busy,done}: got %b want 000",
                         c, {step_en, busy, done});
            end
        end
    endtask

    task automatic test_random();
        int q0, tgt;
        for (int i = 0; i < 16; i++) begin
            q0  = int'($urandom_range(3, 0));
            tgt = int'($urandom_range(3, 0));
            run_move(q0, tgt, 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_target = 2'd0;
        frozen     = 1'b0;
        q_load     = 1'b1;
        q_load_val = 2'd0;
        tick();
        tick();
        q_load = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        test_reset();
        run_move(0, 0, 1'b0);   // no steps, done in cycle 1
        run_move(1, 2, 1'b0);   // one step up
        run_move(0, 3, 1'b0);   // one step down across the wrap
        run_move(1, 3, 1'b0);   // two steps, tie resolves up
        run_move(3, 1, 1'b1);   // two steps, req_valid held while busy
        test_timeout();
        test_reset_in_dwell();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
